// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, the load/store port and the
// memory-side strobes shared by the arbiter. The slave modport is the arbiter's
// view; the master modport is the view of the surrounding cpu and memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_rd, m_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, m_addr, m_wdata, m_rd, m_wr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the load/store port. Every access runs IDLE -> ACCESS -> DONE,
// holding the memory strobe for MEM_LATENCY cycles (legal range 1..15) and then
// returning a one-cycle ack with registered read data to the granted port.
// Optional build macro ARB_ROUND_ROBIN_EN: on a simultaneous request the port
// not granted last wins; without it the data port always wins.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] CNT_LOAD  = 4'(MEM_LATENCY - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              grant_d;
    logic              acc_wr;
    logic [DATA_W-1:0] rdata_q;

    logic              any_req;
    logic              pick_d;
    logic [ADDR_W-1:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic              last_d;

    // Winner selection: alternate on contention, a lone requester always wins
    always_comb begin
        pick_d = bus.d_req;
        if (bus.d_req && bus.i_req) begin
            pick_d = !last_d;
        end
    end

    // Remember which port received the most recent grant (fetch after reset)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b0;
        end else if (state == ST_IDLE && any_req) begin
            last_d <= pick_d;
        end
    end
`else
    // Winner selection: data port always beats the fetch port
    always_comb begin
        pick_d = bus.d_req;
    end
`endif

    // Request presence and the address of whichever port is about to be granted
    always_comb begin
        any_req  = bus.i_req || bus.d_req;
        sel_addr = pick_d ? bus.d_addr : bus.i_addr;
    end

    // Access sequencer: latch the winner, hold the strobe, capture data, ack once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            grant_d     <= 1'b0;
            acc_wr      <= 1'b0;
            rdata_q     <= '0;
            busy        <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_rd    <= 1'b0;
            bus.m_wr    <= 1'b0;
            bus.i_ack   <= 1'b0;
            bus.d_ack   <= 1'b0;
            bus.i_rdata <= '0;
            bus.d_rdata <= '0;
        end else begin
            bus.i_ack <= 1'b0;
            bus.d_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state       <= ST_ACCESS;
                        cnt         <= CNT_LOAD;
                        grant_d     <= pick_d;
                        acc_wr      <= pick_d && bus.d_wr;
                        bus.m_addr  <= sel_addr;
                        bus.m_wdata <= pick_d ? bus.d_wdata : '0;
                        bus.m_rd    <= !(pick_d && bus.d_wr);
                        bus.m_wr    <= pick_d && bus.d_wr;
                        busy        <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!acc_wr) begin
                            rdata_q <= bus.m_rdata;
                        end
                        bus.m_rd <= 1'b0;
                        bus.m_wr <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    if (grant_d) begin
                        bus.d_ack <= 1'b1;
                        if (!acc_wr) begin
                            bus.d_rdata <= rdata_q;
                        end
                    end else begin
                        bus.i_ack   <= 1'b1;
                        bus.i_rdata <= rdata_q;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    bus.m_rd <= 1'b0;
                    bus.m_wr <= 1'b0;
                end
            endcase
        end
    end
endmodule
